// File: rtl/lcb_fifo_pkg.sv
// Shared constants and helpers for the FIFO-to-AXI-Stream reader slice.
package lcb_fifo_pkg;

  // Upstream sync FIFO returns data one cycle after an accepted read strobe.
  localparam int unsigned FIFO_RD_LATENCY = 1;

  // Depth of the in-order output buffer in front of the AXI-Stream port.
  localparam int unsigned OUT_BUF_DEPTH = 3;

  // Ceiling log2; returns 0 for values of 0 and 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    r = 0;
    if (value > 1) begin
      v = value - 1;
      while (v > 0) begin
        r = r + 1;
        v = v >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_axis_reader_if.sv
// Upstream FIFO read port plus AXI-Stream master port of fifo_axis_reader.
// m_axis_tlast exists only when FIFO_AXIS_READER_TLAST_EN is defined.
interface fifo_axis_reader_if #(
  parameter int unsigned DATA_WIDTH = 16
);

  logic                  fifo_rd_en;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic [DATA_WIDTH-1:0] m_axis_tdata;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;
`ifdef FIFO_AXIS_READER_TLAST_EN
  logic                  m_axis_tlast;
`endif

  // The reader: pulls from the FIFO and drives the stream.
  modport master (
`ifdef FIFO_AXIS_READER_TLAST_EN
    output m_axis_tlast,
`endif
    output fifo_rd_en,
    input  fifo_empty,
    input  fifo_rd_data,
    output m_axis_tdata,
    output m_axis_tvalid,
    input  m_axis_tready
  );

  // The environment: upstream FIFO and downstream stream sink.
  modport slave (
`ifdef FIFO_AXIS_READER_TLAST_EN
    input  m_axis_tlast,
`endif
    input  fifo_rd_en,
    output fifo_empty,
    output fifo_rd_data,
    input  m_axis_tdata,
    input  m_axis_tvalid,
    output m_axis_tready
  );

endinterface

// File: rtl/fifo_axis_out_buf.sv
// Small in-order circular buffer holding words between FIFO read and stream.
module fifo_axis_out_buf
  import lcb_fifo_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 16,
  parameter  int unsigned DEPTH      = OUT_BUF_DEPTH,
  localparam int unsigned CNT_W      = clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [CNT_W-1:0]      count
);

  localparam int unsigned PTR_W = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
  endfunction

  // Pointer and occupancy bookkeeping; simultaneous push and pop keep count.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({push, pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage write port.
  // NOTE: storage is deliberately not reset; occupancy gates every read, so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr_ptr] <= data_in;
  end

  assign data_out = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
  assign count    = r_count;

endmodule

// File: rtl/fifo_axis_reader.sv
// Reads a synchronous FIFO and presents its words as an AXI-Stream master.
// Optional tlast generation is built when FIFO_AXIS_READER_TLAST_EN is defined.
module fifo_axis_reader
  import lcb_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned PACKET_LEN = 16
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                enable,
  fifo_axis_reader_if.master  bus,
  output logic [31:0]         words_sent
);

  localparam int unsigned CNT_W = clog2(OUT_BUF_DEPTH + 1);

  // Packet length must fit the 16-bit beat range.
  if (PACKET_LEN < 1 || PACKET_LEN > 65535) begin : g_bad_packet_len
    $error("fifo_axis_reader: PACKET_LEN out of range 1..65535");
  end

  logic                       w_rd_en;
  logic                       w_push;
  logic                       w_pop;
  logic                       w_tvalid;
  logic [CNT_W-1:0]           w_held;
  logic [DATA_WIDTH-1:0]      w_head;
  logic [FIFO_RD_LATENCY-1:0] r_inflight;
  logic [31:0]                r_words_sent;

  // Read credit counts buffered plus in-flight words so a read never overflows
  // the buffer; tready is deliberately absent to keep the strobe path short.
  assign w_rd_en  = resetn & enable & ~bus.fifo_empty &
                    ((int'(w_held) + $countones(r_inflight)) < int'(OUT_BUF_DEPTH));
  assign w_push   = r_inflight[FIFO_RD_LATENCY-1];
  assign w_tvalid = resetn & (w_held != '0);
  assign w_pop    = w_tvalid & bus.m_axis_tready;

  assign bus.fifo_rd_en    = w_rd_en;
  assign bus.m_axis_tvalid = w_tvalid;
  assign bus.m_axis_tdata  = resetn ? w_head : '0;
  assign words_sent        = r_words_sent;

  // Delay line marking FIFO reads whose data has not yet arrived.
  always_ff @(posedge clk) begin
    if (!resetn) r_inflight <= '0;
    else         r_inflight <= FIFO_RD_LATENCY'({r_inflight, w_rd_en});
  end

  // Handshake counter, wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (!resetn)    r_words_sent <= '0;
    else if (w_pop) r_words_sent <= r_words_sent + 32'd1;
  end

  fifo_axis_out_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (OUT_BUF_DEPTH)
  ) u_out_buf (
    .clk      (clk),
    .resetn   (resetn),
    .push     (w_push),
    .data_in  (bus.fifo_rd_data),
    .pop      (w_pop),
    .data_out (w_head),
    .count    (w_held)
  );

`ifdef FIFO_AXIS_READER_TLAST_EN
  localparam int unsigned BEAT_W = (clog2(PACKET_LEN) < 1) ? 1 : clog2(PACKET_LEN);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PACKET_LEN - 1);

  logic [BEAT_W-1:0] r_beat;

  // Beat position within the packet, advancing on every handshake.
  always_ff @(posedge clk) begin
    if (!resetn)    r_beat <= '0;
    else if (w_pop) r_beat <= (r_beat == LAST_BEAT) ? '0 : r_beat + 1'b1;
  end

  assign bus.m_axis_tlast = w_tvalid & (r_beat == LAST_BEAT);
`endif

endmodule

// File: tb/tb_fifo_axis_reader.sv
// Self-checking bench for fifo_axis_reader: behavioural upstream FIFO,
// stream scoreboard and per-scenario tasks. Define FIFO_AXIS_READER_TLAST_EN
// to also exercise tlast.
module tb_fifo_axis_reader;

  localparam int DW = 16;
  localparam int PL = 4;

  logic        clk    = 1'b0;
  logic        resetn = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] words_sent;

  fifo_axis_reader_if #(.DATA_WIDTH(DW)) bus ();

  fifo_axis_reader #(
    .DATA_WIDTH (DW),
    .PACKET_LEN (PL)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .enable     (enable),
    .bus        (bus.master),
    .words_sent (words_sent)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Upstream FIFO model: words in src[0..wr_cnt-1], read index rd_idx.
  logic [DW-1:0] src [0:255];
  int wr_cnt = 0;
  int rd_idx = 0;

  assign bus.fifo_empty = (rd_idx == wr_cnt);

  always @(posedge clk) begin
    if (!resetn) begin
      rd_idx           <= 0;
      bus.fifo_rd_data <= '0;
    end else if (bus.fifo_rd_en && !bus.fifo_empty) begin
      bus.fifo_rd_data <= src[rd_idx];
      rd_idx           <= rd_idx + 1;
    end else begin
      bus.fifo_rd_data <= DW'($urandom);
    end
  end

  // Scoreboard: stream order, credit bound, handshake count, stability, tlast.
  int            m_beats = 0;
  int            m_reads = 0;
  logic          m_stall = 1'b0;
  logic [DW-1:0] m_stall_data = '0;

  always @(negedge clk) begin
    if (!resetn) begin
      m_beats = 0;
      m_reads = 0;
      m_stall = 1'b0;
    end else begin
      n_vec++;
      if (bus.fifo_rd_en === 1'b1 && bus.fifo_empty) begin
        n_err++; $display("FAIL rd_en_while_empty: rd_en=%b empty=%b", bus.fifo_rd_en, bus.fifo_empty);
      end
      n_vec++;
      if (m_reads - m_beats + int'(bus.fifo_rd_en) > 3) begin
        n_err++; $display("FAIL credit: outstanding=%0d limit=3", m_reads - m_beats + int'(bus.fifo_rd_en));
      end
      n_vec++;
      if (words_sent !== 32'(m_beats)) begin
        n_err++; $display("FAIL words_sent: got %0d expected %0d", words_sent, m_beats);
      end
      if (m_stall) begin
        n_vec++;
        if (bus.m_axis_tvalid !== 1'b1 || bus.m_axis_tdata !== m_stall_data) begin
          n_err++; $display("FAIL stall_stable: tvalid=%b tdata=%h expected tvalid=1 tdata=%h",
                            bus.m_axis_tvalid, bus.m_axis_tdata, m_stall_data);
        end
      end
`ifdef FIFO_AXIS_READER_TLAST_EN
      n_vec++;
      if (bus.m_axis_tlast !== (bus.m_axis_tvalid === 1'b1 && (m_beats % PL) == PL - 1)) begin
        n_err++; $display("FAIL tlast: got %b at beat index %0d tvalid=%b", bus.m_axis_tlast, m_beats, bus.m_axis_tvalid);
      end
`endif
      if (bus.m_axis_tvalid === 1'b1 && bus.m_axis_tready) begin
        n_vec++;
        if (bus.m_axis_tdata !== src[m_beats]) begin
          n_err++; $display("FAIL beat_data: beat %0d got %h expected %h", m_beats, bus.m_axis_tdata, src[m_beats]);
        end
        m_beats++;
      end
      m_stall      = (bus.m_axis_tvalid === 1'b1) && !bus.m_axis_tready;
      m_stall_data = bus.m_axis_tdata;
      m_reads      = m_reads + int'(bus.fifo_rd_en);
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] w);
    src[wr_cnt] = w;
    wr_cnt++;
  endtask

  task automatic do_reset();
    resetn            = 1'b0;
    enable            = 1'b0;
    bus.m_axis_tready = 1'b0;
    wr_cnt            = 0;
    cycle();
    cycle();
    resetn = 1'b1;
  endtask

  task automatic wait_sent(input int n, input int budget, input string name);
    for (int k = 0; k < budget && words_sent !== 32'(n); k++) @(negedge clk);
    n_vec++;
    if (words_sent !== 32'(n)) begin
      n_err++; $display("FAIL %s: words_sent=%0d expected %0d", name, words_sent, n);
    end
  endtask

  // Outputs while reset is held, with work pending upstream.
  task automatic test_reset();
    resetn = 1'b0;
    wr_cnt = 0;
    push(16'hBEEF);
    enable            = 1'b1;
    bus.m_axis_tready = 1'b1;
    cycle();
    cycle();
    n_vec++; if (bus.m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL reset_tvalid: got %b expected 0", bus.m_axis_tvalid); end
    n_vec++; if (bus.fifo_rd_en !== 1'b0)    begin n_err++; $display("FAIL reset_rd_en: got %b expected 0", bus.fifo_rd_en); end
    n_vec++; if (bus.m_axis_tdata !== '0)    begin n_err++; $display("FAIL reset_tdata: got %h expected 0", bus.m_axis_tdata); end
    n_vec++; if (words_sent !== 32'd0)       begin n_err++; $display("FAIL reset_words_sent: got %0d expected 0", words_sent); end
`ifdef FIFO_AXIS_READER_TLAST_EN
    n_vec++; if (bus.m_axis_tlast !== 1'b0)  begin n_err++; $display("FAIL reset_tlast: got %b expected 0", bus.m_axis_tlast); end
`endif
  endtask

  // First read, N+2 latency and one beat per cycle.
  task automatic test_latency();
    do_reset();
    bus.m_axis_tready = 1'b1;
    for (int i = 1; i <= 8; i++) push(DW'(i));
    enable = 1'b1;
    @(negedge clk);
    n_vec++; if (bus.fifo_rd_en !== 1'b1) begin n_err++; $display("FAIL lat_first_rd: rd_en=%b expected 1", bus.fifo_rd_en); end
    @(negedge clk);
    n_vec++; if (bus.m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL lat_n1_tvalid: got %b expected 0", bus.m_axis_tvalid); end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n_vec++;
      if (bus.m_axis_tvalid !== 1'b1 || bus.m_axis_tdata !== DW'(k + 1)) begin
        n_err++; $display("FAIL lat_stream: cycle N+%0d tvalid=%b tdata=%h expected 1/%h", k + 2, bus.m_axis_tvalid, bus.m_axis_tdata, k + 1);
      end
    end
    @(negedge clk);
    n_vec++; if (words_sent !== 32'd8) begin n_err++; $display("FAIL lat_words: got %0d expected 8", words_sent); end
  endtask

  // Stalled sink: exactly three reads, head word held stable.
  task automatic test_backpressure();
    int pulses;
    do_reset();
    for (int i = 0; i < 5; i++) push(DW'($urandom));
    enable = 1'b1;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.fifo_rd_en === 1'b1) pulses++;
      if (bus.m_axis_tvalid === 1'b1) begin
        n_vec++;
        if (bus.m_axis_tdata !== src[0]) begin n_err++; $display("FAIL bp_head: got %h expected %h", bus.m_axis_tdata, src[0]); end
      end
    end
    n_vec++; if (pulses != 3) begin n_err++; $display("FAIL bp_pulses: got %0d expected 3", pulses); end
    cycle();
    bus.m_axis_tready = 1'b1;
    wait_sent(5, 40, "bp_drain");
  endtask

  // Alternating ready over a 20-word stream.
  task automatic test_toggle();
    do_reset();
    for (int i = 0; i < 20; i++) push(DW'($urandom));
    bus.m_axis_tready = 1'b1;
    enable = 1'b1;
    for (int k = 0; k < 200 && words_sent !== 32'd20; k++) begin
      cycle();
      bus.m_axis_tready = ~bus.m_axis_tready;
    end
    bus.m_axis_tready = 1'b1;
    repeat (6) cycle();
    n_vec++; if (words_sent !== 32'd20) begin n_err++; $display("FAIL toggle_count: got %0d expected 20", words_sent); end
  endtask

  // Enable dropped right after the first read strobe.
  task automatic test_enable_drop();
    int pulses;
    do_reset();
    bus.m_axis_tready = 1'b1;
    for (int i = 0; i < 6; i++) push(DW'($urandom));
    enable = 1'b1;
    @(negedge clk);
    n_vec++; if (bus.fifo_rd_en !== 1'b1) begin n_err++; $display("FAIL en_first_rd: rd_en=%b expected 1", bus.fifo_rd_en); end
    cycle();
    enable = 1'b0;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.fifo_rd_en === 1'b1) pulses++;
    end
    n_vec++; if (pulses != 0) begin n_err++; $display("FAIL en_no_reads: got %0d expected 0", pulses); end
    n_vec++; if (words_sent !== 32'd1) begin n_err++; $display("FAIL en_inflight: words_sent=%0d expected 1", words_sent); end
    cycle();
    enable = 1'b1;
    wait_sent(6, 40, "en_resume");
  endtask

  // Random enable, ready and refill; scoreboard checks every cycle.
  task automatic test_random();
    do_reset();
    for (int k = 0; k < 400; k++) begin
      cycle();
      bus.m_axis_tready = 1'($urandom_range(0, 1));
      enable            = ($urandom_range(0, 3) != 0);
      if (wr_cnt < 80 && $urandom_range(0, 2) == 0) push(DW'($urandom));
    end
    enable            = 1'b1;
    bus.m_axis_tready = 1'b1;
    wait_sent(wr_cnt, 200, "rand_drain");
  endtask

`ifdef FIFO_AXIS_READER_TLAST_EN
  // Packet boundaries at beats 4 and 8; counter resumes at 2 after 10 beats.
  task automatic test_tlast();
    int b;
    logic [15:0] mask;
    do_reset();
    bus.m_axis_tready = 1'b1;
    for (int i = 0; i < 10; i++) push(DW'($urandom));
    enable = 1'b1;
    b = 0;
    mask = '0;
    for (int k = 0; k < 60 && b < 12; k++) begin
      @(negedge clk);
      if (bus.m_axis_tvalid === 1'b1) begin
        b++;
        if (bus.m_axis_tlast === 1'b1) mask[b] = 1'b1;
      end
      if (b == 10 && wr_cnt == 10) begin
        n_vec++;
        if (mask !== 16'h0110) begin n_err++; $display("FAIL tlast_first10: mask=%h expected 0110", mask); end
        cycle();
        push(DW'($urandom));
        push(DW'($urandom));
      end
    end
    n_vec++; if (mask !== 16'h1110) begin n_err++; $display("FAIL tlast_resume: mask=%h expected 1110", mask); end
  endtask
`endif

  // Reset with two words buffered and one in flight, then refill.
  task automatic test_reset_mid();
    int b;
    int first_last;
    logic [DW-1:0] first_data;
    logic seen;
    do_reset();
    for (int i = 0; i < 4; i++) push(DW'($urandom));
    enable = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      seen = (bus.m_axis_tvalid === 1'b1);
    end
    n_vec++; if (!seen) begin n_err++; $display("FAIL mid_fill: tvalid never rose, expected 1"); end
    cycle();
    resetn = 1'b0;
    wr_cnt = 0;
    cycle();
    n_vec++; if (bus.m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL mid_tvalid: got %b expected 0", bus.m_axis_tvalid); end
    n_vec++; if (words_sent !== 32'd0)       begin n_err++; $display("FAIL mid_words: got %0d expected 0", words_sent); end
    resetn = 1'b1;
    for (int i = 0; i < PL + 2; i++) push(DW'($urandom));
    bus.m_axis_tready = 1'b1;
    b = 0;
    first_last = 0;
    first_data = '0;
    for (int k = 0; k < 40 && b < PL + 2; k++) begin
      @(negedge clk);
      if (bus.m_axis_tvalid === 1'b1) begin
        b++;
        if (b == 1) first_data = bus.m_axis_tdata;
`ifdef FIFO_AXIS_READER_TLAST_EN
        if (bus.m_axis_tlast === 1'b1 && first_last == 0) first_last = b;
`endif
      end
    end
    n_vec++; if (first_data !== src[0]) begin n_err++; $display("FAIL mid_first_data: got %h expected %h", first_data, src[0]); end
`ifdef FIFO_AXIS_READER_TLAST_EN
    n_vec++; if (first_last != PL) begin n_err++; $display("FAIL mid_tlast_pos: got %0d expected %0d", first_last, PL); end
`endif
    wait_sent(PL + 2, 10, "mid_refill");
  endtask

  initial begin
    bus.m_axis_tready = 1'b0;
    test_reset();
    test_latency();
    test_backpressure();
    test_toggle();
    test_enable_drop();
    test_random();
`ifdef FIFO_AXIS_READER_TLAST_EN
    test_tlast();
`endif
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/fifo_axis_reader.md
FIFO_AXIS_READER -- requirements
Module: fifo_axis_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 16: width of the FIFO word and of m_axis_tdata.
REQ-002 Parameter PACKET_LEN, default 16: beats per packet for tlast generation, legal range 1..65535.
REQ-003 clk  input  1  clock; all logic is on the rising edge.
REQ-004 resetn  input  1  reset, synchronous, active-low.
REQ-005 enable  input  1  permits new FIFO reads when high.
REQ-006 fifo_rd_en  output  1  read strobe to the upstream sync FIFO.
REQ-007 fifo_empty  input  1  upstream FIFO empty flag.
REQ-008 fifo_rd_data  input  DATA_WIDTH  FIFO data, valid in the cycle after a cycle with fifo_rd_en=1 and fifo_empty=0.
REQ-009 m_axis_tdata  output  DATA_WIDTH  AXI-Stream data.
REQ-010 m_axis_tvalid  output  1  AXI-Stream valid.
REQ-011 m_axis_tready  input  1  AXI-Stream ready.
REQ-012 m_axis_tlast  output  1  end of packet; this port exists only with FIFO_AXIS_READER_TLAST_EN.
REQ-013 words_sent  output  32  count of completed AXI-Stream handshakes.

Function
REQ-014 The block SHALL hold an internal 3-entry in-order output buffer with occupancy held (0..3), and an in-flight flag inflight (0..1).
REQ-015 fifo_rd_en SHALL equal enable & ~fifo_empty & (held + inflight < 3), decoded from registers and inputs only, with no combinational path from m_axis_tready.
REQ-016 When fifo_rd_en=1 in cycle N, inflight SHALL be 1 in cycle N+1, and fifo_rd_data SHALL be written into the buffer at the end of N+1.
REQ-017 m_axis_tvalid SHALL equal (held != 0), and m_axis_tdata SHALL be the oldest buffered word.
REQ-018 A beat transfers when tvalid & tready; the head entry is then popped at that edge.
REQ-019 A push and a pop in the same cycle SHALL leave held unchanged and preserve word order.
REQ-020 Latency from a fifo_rd_en cycle N into an empty buffer SHALL be: tvalid=1 in cycle N+2.
REQ-021 With tready held at 1, enable=1 and the FIFO non-empty, throughput SHALL be one beat per cycle after the initial latency.
REQ-022 While tvalid=1 and tready=0, tdata (and tlast) SHALL stay stable, and tvalid SHALL NOT drop.
REQ-023 When enable=0, no new reads SHALL be issued; an in-flight word is still captured, and buffered words are still presented.
REQ-024 fifo_rd_en SHALL never assert while fifo_empty=1, and SHALL never assert when the buffer plus the in-flight word would exceed 3.
REQ-025 words_sent SHALL increment by 1 per handshake and wrap from 2^32-1 to 0.

Reset
REQ-026 When resetn=0 at an edge, the following SHALL clear to 0: held, inflight, buffer pointers, words_sent and the beat counter.
REQ-027 During reset, outputs SHALL be: m_axis_tvalid=0, m_axis_tlast=0, fifo_rd_en=0, m_axis_tdata=0.
REQ-028 A reset mid-operation SHALL discard buffered and in-flight words; the upstream FIFO is reset by the same resetn.

Configuration
REQ-029 With macro FIFO_AXIS_READER_TLAST_EN defined, the block SHALL include a beat counter of width clog2(PACKET_LEN).
REQ-030 With FIFO_AXIS_READER_TLAST_EN defined, m_axis_tlast SHALL be 1 exactly when tvalid=1 and the beat counter equals PACKET_LEN-1.
REQ-031 With FIFO_AXIS_READER_TLAST_EN defined, the beat counter SHALL advance on each handshake and wrap to 0 after PACKET_LEN-1; PACKET_LEN=1 gives tlast on every beat.
REQ-032 Without the macro, the m_axis_tlast port and the beat counter SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-033 The shared package lcb_fifo_pkg SHALL hold FIFO_RD_LATENCY=1 and OUT_BUF_DEPTH=3, plus the clog2 helper function.
REQ-034 The 3-entry buffer SHALL be the sub-module fifo_axis_out_buf, with push/data_in/pop/data_out/count ports; the top level SHALL hold the read-credit, inflight, counter and tlast logic.

Verification
REQ-035 Scenario: preload 8 words 0x0001..0x0008, enable=1, tready=1 -> fifo_rd_en first high in cycle N, tvalid high in N+2, 8 consecutive beats in order, words_sent=8.
REQ-036 Scenario: preload 5 words, tready=0 for 10 cycles -> exactly 3 fifo_rd_en pulses, tdata=first word held stable; on tready=1, the remaining 5 beats arrive in order.
REQ-037 Scenario: tready toggling 1,0,1,0 with a 20-word stream -> no word lost or duplicated, and fifo_rd_en never high while fifo_empty=1.
REQ-038 Scenario: enable dropped in the cycle fifo_rd_en=1 -> that word is still delivered, and no further reads occur until enable=1.
REQ-039 Scenario: with TLAST_EN and PACKET_LEN=4, send 10 beats -> tlast on beats 4 and 8; the beat counter is at 2 afterwards.
REQ-040 Scenario: resetn=0 for 1 cycle with held=2 -> next cycle tvalid=0 and words_sent=0; after refill, the first beat's tlast position restarts at beat PACKET_LEN.
